// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared event codes and FIFO entry type for button_event_ctrl
package button_event_pkg;

  typedef logic [1:0] evt_code_t;

  localparam evt_code_t EVT_RELEASE = 2'b00;
  localparam evt_code_t EVT_PRESS   = 2'b01;
  localparam evt_code_t EVT_LONG    = 2'b10;

  // Wide enough for the largest supported channel count (16).
  localparam int ID_W_MAX = 4;

  typedef struct packed {
    evt_code_t           code;
    logic [ID_W_MAX-1:0] id;
  } evt_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - per-channel synchronizer, debouncer and event strobe
// Hold counter and LONG strobe are built only when BUTTON_EVENT_LONG_PRESS_EN is defined.
module btn_debounce_ch
  import button_event_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int LONG_CYC     = 1000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      btn,
  output logic      state,
  output logic      evt,
  output evt_code_t code
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYC - 1);

  logic        sync1;
  logic        s;
  logic        last;
  logic [15:0] cnt;
  logic        accept;
  evt_code_t   edge_code;

  assign accept    = (cnt == CNT_MAX) && (last != state);
  assign edge_code = last ? EVT_PRESS : EVT_RELEASE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      last  <= 1'b0;
      cnt   <= '0;
      state <= 1'b0;
    end else begin
      sync1 <= btn;
      s     <= sync1;
      last  <= s;
      if (s != last) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 16'd1;
      end
      if (accept) begin
        state <= last;
      end
    end
  end

`ifdef BUTTON_EVENT_LONG_PRESS_EN
  localparam int                HOLD_W    = $clog2(LONG_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYC - 1);

  logic [HOLD_W-1:0] hold;
  logic              long_hit;

  // A release accepted on the same edge wins: the button is no longer held.
  assign long_hit = state && !accept && (hold == HOLD_FIRE);

  always_ff @(posedge clk) begin
    if (!rst_n || !state) begin
      hold <= '0;
    end else if (hold != HOLD_END) begin
      hold <= hold + HOLD_W'(1);
    end
  end

  assign evt  = accept || long_hit;
  assign code = accept ? edge_code : EVT_LONG;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = (LONG_CYC != 0);
  assign evt  = accept;
  assign code = edge_code;
`endif

endmodule

// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - button debounce/event block: pending slots, RR scheduler, event FIFO
// LONG events are produced only when BUTTON_EVENT_LONG_PRESS_EN is defined.
module button_event_ctrl
  import button_event_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 20,
  parameter int LONG_CYC     = 1000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [N_BTN-1:0]                           btn_in,
  output logic [N_BTN-1:0]                           btn_state,
  output logic                                       evt_valid,
  input  logic                                       evt_ready,
  output logic [1:0]                                 evt_code,
  output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] evt_id,
  output logic                                       overflow,
  input  logic                                       overflow_clr
);

  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [N_BTN-1:0] raise;
  evt_code_t        raise_code [N_BTN];
  logic [N_BTN-1:0] pend_v;
  evt_code_t        pend_code  [N_BTN];

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_next;
  logic [ID_W-1:0]  gidx;
  logic [ID_W-1:0]  cand;
  logic [ID_W:0]    sum;
  logic             grant;

  evt_t             mem [FIFO_DEPTH];
  evt_t             last_pop;
  evt_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop;
  logic             can_push;
  logic             drop;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_in[i]),
      .state(btn_state[i]),
      .evt  (raise[i]),
      .code (raise_code[i])
    );
  end

  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign can_push  = (count != (AW+1)'(FIFO_DEPTH)) || pop;
  assign drop      = |(raise & pend_v);

  // Round-robin: search starts at rr_ptr, which always names the channel after the last grant.
  always_comb begin
    grant   = 1'b0;
    gidx    = '0;
    cand    = '0;
    sum     = '0;
    rr_next = rr_ptr;
    for (int k = 0; k < N_BTN; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_BTN)) begin
        sum = sum - (ID_W+1)'(N_BTN);
      end
      cand = sum[ID_W-1:0];
      if (can_push && !grant && pend_v[cand]) begin
        grant = 1'b1;
        gidx  = cand;
      end
    end
    sum = {1'b0, gidx} + (ID_W+1)'(1);
    if (sum >= (ID_W+1)'(N_BTN)) begin
      sum = sum - (ID_W+1)'(N_BTN);
    end
    if (grant) begin
      rr_next = sum[ID_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_v   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        pend_code[i] <= EVT_RELEASE;
      end
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_pop <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (grant && (gidx == ID_W'(i))) begin
          pend_v[i] <= 1'b0;
        end
        if (raise[i] && !pend_v[i]) begin
          pend_v[i]    <= 1'b1;
          pend_code[i] <= raise_code[i];
        end
      end
      rr_ptr <= rr_next;
      if (grant) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        last_pop <= mem[rd_ptr];
      end
      if (grant && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (!grant && pop) begin
        count <= count - (AW+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr; the old head is read before the write lands.
  always_ff @(posedge clk) begin
    if (grant) begin
      mem[wr_ptr] <= '{code: pend_code[gidx], id: ID_W_MAX'(gidx)};
    end
  end

  // An empty FIFO keeps presenting the last popped entry.
  assign head     = evt_valid ? mem[rd_ptr] : last_pop;
  assign evt_code = head.code;
  assign evt_id   = ID_W'(head.id);

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - self-checking bench for button_event_ctrl (honours BUTTON_EVENT_LONG_PRESS_EN)
module tb_button_event_ctrl;

  localparam int N     = 4;
  localparam int DEB   = 20;
  localparam int LONG  = 100;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         evt_ready = 1'b0;
  logic         overflow_clr = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_state;
  logic         evt_valid;
  logic         overflow;
  logic [1:0]   evt_code;
  logic [1:0]   evt_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .N_BTN       (N),
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LONG),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .btn_state   (btn_state),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_id      (evt_id),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: pin history per channel, pending slots, FIFO as a queue.
  // Queue entries are {code[1:0], id[3:0]}.
  logic [63:0] h [N];
  bit          st [N];
  int          rise [N];
  bit          pv [N];
  logic [1:0]  pc [N];
  int          ptr = 0;
  bit          movf = 1'b0;
  bit          just_reset = 1'b0;
  logic [5:0]  q [$];
  logic [5:0]  evlog [$];

  always @(posedge clk) begin
    logic [N-1:0] raise;
    logic [1:0]   rc [N];
    bit           pv_old [N];
    int           g;
    bit           pop;
    bit           drop;
    logic [N-1:0] est;
    logic [5:0]   hd;

    cyc++;
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        h[c] = '0; st[c] = 1'b0; pv[c] = 1'b0; pc[c] = 2'b00; rise[c] = 0;
      end
      q.delete();
      ptr = 0;
      movf = 1'b0;
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      raise = '0;
      for (int c = 0; c < N; c++) begin
        bit v;
        bit stable;
        rc[c] = 2'b00;
        h[c] = {h[c][62:0], btn_in[c]};
        // A level is accepted once DEB consecutive pin samples, ending 3 edges ago, agree.
        v = h[c][3];
        stable = 1'b1;
        for (int b = 3; b <= DEB + 2; b++) begin
          if (h[c][b] != v) stable = 1'b0;
        end
        if (stable && (v != st[c])) begin
          st[c] = v;
          raise[c] = 1'b1;
          rc[c] = v ? 2'b01 : 2'b00;
          if (v) rise[c] = cyc;
        end
`ifdef BUTTON_EVENT_LONG_PRESS_EN
        else if (st[c] && (cyc == rise[c] + LONG)) begin
          raise[c] = 1'b1;
          rc[c] = 2'b10;
        end
`endif
      end

      pop = (q.size() > 0) && evt_ready;
      g = -1;
      if ((q.size() < DEPTH) || pop) begin
        for (int i = 0; i < N; i++) begin
          if ((g < 0) && pv[(ptr + i) % N]) g = (ptr + i) % N;
        end
      end
      for (int c = 0; c < N; c++) pv_old[c] = pv[c];
      if (pop) evlog.push_back(q.pop_front());
      if (g >= 0) begin
        q.push_back({pc[g], 4'(g)});
        pv[g] = 1'b0;
        ptr = (g + 1) % N;
      end
      drop = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (raise[c]) begin
          if (pv_old[c]) drop = 1'b1;
          else begin
            pv[c] = 1'b1;
            pc[c] = rc[c];
          end
        end
      end
      if (drop) movf = 1'b1;
      else if (overflow_clr) movf = 1'b0;
    end

    #1;
    for (int c = 0; c < N; c++) est[c] = st[c];
    check("outputs", int'({btn_state, evt_valid, overflow}), int'({est, q.size() != 0, movf}));
    if (q.size() != 0) begin
      hd = q[0];
      check("head", evt_code * 16 + evt_id, hd[5:4] * 16 + hd[3:0]);
    end
    if (just_reset) check("reset_head", evt_code * 16 + evt_id, 0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_log(input string name, input int idx, input int code, input int id);
    logic [5:0] e;
    if (idx < evlog.size()) begin
      e = evlog[idx];
      check(name, e[5:4] * 16 + e[3:0], code * 16 + id);
    end else begin
      check(name, -1, code * 16 + id);
    end
  endtask

  initial begin
    int m;
    int n_press;
    int n_rel;
    logic [5:0] e;

    tick(3);
    check("rst_state", int'(btn_state), 0);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_head", evt_code * 16 + evt_id, 0);
    check("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    tick(2);

    // Clean press on channel 1: state rises 22 edges after the pin is first sampled.
    m = evlog.size();
    btn_in[1] = 1'b1;
    tick(22);
    check("t1_state_before", int'(btn_state[1]), 0);
    tick(1);
    check("t1_state_rise", int'(btn_state[1]), 1);
    check("t1_valid_same", int'(evt_valid), 0);
    tick(1);
    check("t1_valid", int'(evt_valid), 1);
    check("t1_head", evt_code * 16 + evt_id, 1 * 16 + 1);
    evt_ready = 1'b1;
    tick(1);
    check("t1_drained", int'(evt_valid), 0);
    check_log("t1_log", m, 1, 1);

    // Bounce on channel 0: 5-cycle runs never qualify.
    m = evlog.size();
    for (int t = 0; t < 20; t++) begin
      btn_in[0] = ~btn_in[0];
      tick(5);
    end
    check("t2_no_accept", int'(btn_state[0]), 0);
    btn_in[0] = 1'b1;
    tick(40);
    check("t2_state", int'(btn_state[0]), 1);
    n_press = 0;
    n_rel = 0;
    for (int i = m; i < evlog.size(); i++) begin
      e = evlog[i];
      if (e[3:0] == 4'd0 && e[5:4] == 2'b01) n_press++;
      if (e[3:0] == 4'd0 && e[5:4] == 2'b00) n_rel++;
    end
    check("t2_press_cnt", n_press, 1);
    check("t2_release_cnt", n_rel, 0);

    btn_in = '0;
    tick(40);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Simultaneous bursts; RR pointer starts at 0 after reset.
    m = evlog.size();
    btn_in = 4'hF;
    tick(30);
    btn_in = 4'b1101;
    tick(28);
    btn_in = 4'b0000;
    tick(30);
    check_log("t3_e0", m + 0, 1, 0);
    check_log("t3_e1", m + 1, 1, 1);
    check_log("t3_e2", m + 2, 1, 2);
    check_log("t3_e3", m + 3, 1, 3);
    check_log("t3_e4", m + 4, 0, 1);
    check_log("t3_e5", m + 5, 0, 2);
    check_log("t3_e6", m + 6, 0, 3);
    check_log("t3_e7", m + 7, 0, 0);

    // Overflow: FIFO and pending slots fill, re-press is dropped. Pointer enters at 1.
    evt_ready = 1'b0;
    m = evlog.size();
    btn_in = 4'hF;
    tick(30);
    check("t4_full_valid", int'(evt_valid), 1);
    btn_in = 4'h0;
    tick(30);
    check("t4_no_ovf_yet", int'(overflow), 0);
    btn_in = 4'hF;
    tick(25);
    check("t4_ovf_set", int'(overflow), 1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("t4_ovf_clr", int'(overflow), 0);
    evt_ready = 1'b1;
    tick(12);
    check_log("t4_e0", m + 0, 1, 1);
    check_log("t4_e1", m + 1, 1, 2);
    check_log("t4_e2", m + 2, 1, 3);
    check_log("t4_e3", m + 3, 1, 0);
    check_log("t4_e4", m + 4, 0, 1);
    check_log("t4_e5", m + 5, 0, 2);
    check_log("t4_e6", m + 6, 0, 3);
    check_log("t4_e7", m + 7, 0, 0);
    btn_in = 4'h0;
    tick(40);

    // Long hold on channel 2.
    m = evlog.size();
    btn_in = 4'b0100;
    tick(300);
    btn_in = 4'b0000;
    tick(40);
    check_log("t5_press", m, 1, 2);
`ifdef BUTTON_EVENT_LONG_PRESS_EN
    check_log("t5_long", m + 1, 2, 2);
    check_log("t5_release", m + 2, 0, 2);
    check("t5_count", evlog.size() - m, 3);
`else
    check_log("t5_release", m + 1, 0, 2);
    check("t5_count", evlog.size() - m, 2);
`endif

    // Reset with three events queued while channel 0 is held.
    evt_ready = 1'b0;
    btn_in = 4'b1110;
    tick(30);
    check("t6_queued", int'(evt_valid), 1);
    rst_n = 1'b0;
    btn_in = 4'b0001;
    tick(1);
    rst_n = 1'b1;
    check("t6_rst_valid", int'(evt_valid), 0);
    check("t6_rst_state", int'(btn_state), 0);
    check("t6_rst_head", evt_code * 16 + evt_id, 0);
    tick(23);
    check("t6_valid_early", int'(evt_valid), 0);
    tick(1);
    check("t6_valid", int'(evt_valid), 1);
    check("t6_head", evt_code * 16 + evt_id, 1 * 16 + 0);

    evt_ready = 1'b1;
    btn_in = 4'b0000;
    tick(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Debounces `N_BTN` raw switch inputs, turns each stable transition into a press, release or long-press event, and schedules those events round-robin into a small FIFO. Software or a downstream FSM drains the FIFO through a valid/ready handshake. The block sits between the board push-buttons/switches and the control logic, and replaces per-button ad-hoc debouncing and edge detection.

## Interface
- `N_BTN`, 4: number of button channels (1..16).
- `DEBOUNCE_CYC`, 20: consecutive stable synchronized samples required to accept a level (2..2^16-1).
- `LONG_CYC`, 1000: cycles of debounced-high before one LONG event is emitted (at least `DEBOUNCE_CYC`).
- `FIFO_DEPTH`, 4: event FIFO entries (power of two, at least 2).
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `btn_in`, in, `N_BTN`: raw asynchronous button levels, 1 = pressed.
- `btn_state`, out, `N_BTN`: debounced level per channel.
- `evt_valid`, out, 1: FIFO head holds an event.
- `evt_ready`, in, 1: consumer accepts the head when `evt_valid` is also high.
- `evt_code`, out, 2: event type: 00 RELEASE, 01 PRESS, 10 LONG.
- `evt_id`, out, `$clog2(N_BTN)` (minimum 1): channel index of the head event.
- `overflow`, out, 1: sticky; an event was dropped.
- `overflow_clr`, in, 1: clears `overflow`.

## Operation
- **Synchronizer.** Each channel passes `btn_in` through a two-flop synchronizer to produce `s`.
- **Debounce.**
  - Each channel keeps `last` (the previous value of `s`) and a counter `cnt`.
  - When `s != last`: `cnt` is cleared to 0.
  - Otherwise `cnt` increments, saturating at `DEBOUNCE_CYC-1`.
  - When `cnt == DEBOUNCE_CYC-1` and `last != btn_state[i]`, `btn_state[i]` takes `last` and the channel raises a PRESS (0→1) or RELEASE (1→0) event.
- **Long press.**
  - While `btn_state[i]==1`, a hold counter increments.
  - When it reaches `LONG_CYC`, the channel raises one LONG event and the counter stops.
  - The hold counter clears when `btn_state[i]` returns to 0.
  - At most one LONG event is emitted per press.
- **Pending slot.**
  - Each channel has a one-entry pending register.
  - If an event is raised while the slot is occupied, the new event is dropped and `overflow` is set.
- **Scheduler.**
  - Each cycle, if the FIFO can accept a push, the scheduler picks one occupied pending slot by round-robin.
  - The search starts at the channel after the last granted one; the pointer resets to channel 0.
  - The selected event is pushed and its slot is freed.
  - Only one push happens per cycle.
- **FIFO can accept** when it is not full, or when it is full and a pop occurs in the same cycle.
- **FIFO empty.** `evt_valid` is 0 and `evt_code`/`evt_id` hold their last value. Consumers must ignore them.
- **Handshake.** A pop occurs when `evt_valid && evt_ready`. `evt_valid` may not drop until the head is popped.
- **Overflow.** `overflow_clr` clears `overflow`. If a drop occurs in the same cycle as `overflow_clr`, set wins.
- **Reset.**
  - Outputs: `btn_state`=0, `evt_valid`=0, `evt_code`=0, `evt_id`=0, `overflow`=0.
  - Internal: synchronizers, counters and pending slots are cleared, the FIFO is emptied and the RR pointer is 0.
  - Reset mid-operation discards all queued and pending events.
  - A button held through reset debounces afterwards and yields a PRESS event.

## Timing
- A pin edge sampled at clock edge k changes `btn_state` at edge k+2+`DEBOUNCE_CYC`, provided the pin stays stable.
- The pending slot is set at the same edge that `btn_state` changes (edge E).
- The push happens at edge E+1 if the slot wins arbitration and the FIFO can accept.
- `evt_valid` is high after edge E+1 when the FIFO was empty. Best-case pin-to-valid latency is `DEBOUNCE_CYC`+3 cycles.
- LONG is raised at the edge where the hold counter reaches `LONG_CYC`, which is `LONG_CYC` cycles after `btn_state` rose.
- Throughput is one push and one pop per cycle. A full FIFO with continuous `evt_ready` sustains 1 event/cycle.

## Configuration
- Macro: `BUTTON_EVENT_LONG_PRESS_EN`.
- **Defined:** hold counters and LONG events exist as described.
- **Undefined:**
  - No hold counters are built and `LONG_CYC` is ignored.
  - Code 10 is never produced.
  - All other behaviour is unchanged.

## Structure
- **Package `button_event_pkg`:**
  - Constants `EVT_RELEASE`=2'b00, `EVT_PRESS`=2'b01, `EVT_LONG`=2'b10.
  - `typedef evt_code_t` (2 bits).
  - A packed struct `evt_t {code, id}` used for FIFO entries.
- **Sub-module `btn_debounce_ch`:** one per channel, generate loop. It contains the synchronizer, debounce counter, hold counter and event strobes.
- **Top level:** holds the pending slots, round-robin scheduler, FIFO and overflow flag.

## Test plan
- **Clean press.** `DEBOUNCE_CYC`=20; `btn_in[1]` 0→1, held.
  - `btn_state[1]` rises exactly 22 cycles later.
  - One event appears: `evt_code`=01, `evt_id`=1, `evt_valid` high one cycle after `btn_state` rises.
- **Bounce rejection.** Toggle `btn_in[0]` every 5 cycles for 100 cycles, then hold at 1.
  - Exactly one PRESS is emitted, and only after 20 stable cycles.
  - No RELEASE is emitted.
- **Simultaneous events.** Channels 0–3 press in the same cycle, `evt_ready`=1.
  - Events pop on consecutive cycles in order id 0,1,2,3.
  - A second simultaneous burst follows the rotated RR order.
- **Overflow.** `FIFO_DEPTH`=4, `evt_ready`=0; all channels press, then release.
  - The FIFO fills and the pending slots fill.
  - Further events are dropped and `overflow`=1.
  - `overflow_clr` pulse → `overflow`=0.
  - Draining yields no corrupted entries.
- **Long press (macro defined).** `LONG_CYC`=100; hold `btn_in[2]` for 300 cycles, then release.
  - Sequence is PRESS, LONG (exactly once), RELEASE.
  - With the macro undefined: PRESS and RELEASE only.
- **Reset mid-operation.** 3 events queued, `rst_n`=0 for one cycle while `btn_in[0]`=1.
  - `evt_valid`=0 and `btn_state`=0.
  - One PRESS for id 0 appears `DEBOUNCE_CYC`+3 cycles after reset release.
